// File: rtl/msg_pkg.sv
// Shared types and constants for the message scroller display path.
package msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } scroll_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         ASCII_W     = 8;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate divider: counts 0..TICK_DIV-1 while run, pulses tick on the last count.
// Latency: tick is combinational from the counter, one cycle wide, every TICK_DIV run cycles.
// Backpressure: none; clear zeroes the count, deasserting run holds it in place.
module scroll_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/message_scroller.sv
// Message buffer plus a NUM_DIGITS-wide scrolling window, one ASCII byte per digit.
// Latency: digit_ascii is registered, 1 cycle after a window move or buffer write lands.
// Backpressure: none; enable=0 freezes the window, writes are accepted every cycle.
module message_scroller
    import msg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 16,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          restart,
    input  logic                          wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]    wr_addr,
    input  logic [7:0]                    wr_data,
    output logic [NUM_DIGITS*8-1:0]       digit_ascii,
    output logic [$clog2(MSG_LEN)-1:0]    win_pos,
    output logic                          wrap_pulse,
    output logic                          running
);

    localparam int            AW       = $clog2(MSG_LEN);
    localparam logic [AW-1:0] LAST_POS = AW'(MSG_LEN - 1);

    scroll_state_t                 state_q, state_d;
    logic [ASCII_W-1:0]            msg_q [MSG_LEN];
    logic [AW-1:0]                 pos_q;
    logic                          tick;
    logic [NUM_DIGITS*ASCII_W-1:0] win_d;

    // Window index wrap: i < NUM_DIGITS <= MSG_LEN, so one subtract is enough.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int i);
        logic [AW:0] s;
        s = {1'b0, p} + (AW+1)'(i);
        if (s >= (AW+1)'(MSG_LEN)) s = s - (AW+1)'(MSG_LEN);
        return s[AW-1:0];
    endfunction

    scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (restart || (state_q == IDLE)),
        .run   (state_q == RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = HOLD;
            HOLD:    if (enable)  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            win_d[ASCII_W*(NUM_DIGITS-1-i) +: ASCII_W] = msg_q[wrap_add(pos_q, i)];
        end
    end

    // Per-entry address match leaves out-of-range addresses with no target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= ASCII_SPACE;
        end else if (wr_en) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if (wr_addr == AW'(i)) msg_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            running     <= 1'b0;
            pos_q       <= '0;
            wrap_pulse  <= 1'b0;
            digit_ascii <= {NUM_DIGITS{ASCII_SPACE}};
        end else begin
            state_q     <= state_d;
            running     <= (state_d == RUN);
            wrap_pulse  <= tick && !restart && (pos_q == LAST_POS);
            digit_ascii <= win_d;
            if (restart) begin
                pos_q <= '0;
            end else if (tick) begin
                pos_q <= (pos_q == LAST_POS) ? '0 : pos_q + AW'(1);
            end
        end
    end

    assign win_pos = pos_q;

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: cycle scoreboard against a behavioural model plus directed checks.
module tb_message_scroller;

    localparam int ND = 4;
    localparam int ML = 8;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [31:0] digit_ascii;
    logic [2:0]  win_pos;
    logic        wrap_pulse;
    logic        running;

    // Second instance with a non power-of-two depth, so addresses 6 and 7 are out of range.
    logic        en6 = 1'b0;
    logic        rs6 = 1'b0;
    logic [31:0] dig6;
    logic [2:0]  pos6;
    logic        wrap6;
    logic        run6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    message_scroller #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_ascii(digit_ascii), .win_pos(win_pos),
        .wrap_pulse(wrap_pulse), .running(running)
    );

    message_scroller #(.NUM_DIGITS(ND), .MSG_LEN(6), .TICK_DIV(TD)) dut6 (
        .clk(clk), .rst_n(rst_n), .enable(en6), .restart(rs6),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_ascii(dig6), .win_pos(pos6),
        .wrap_pulse(wrap6), .running(run6)
    );

    typedef struct packed {
        logic [31:0] dig;
        logic [2:0]  pos;
        logic        wrap;
        logic        run;
    } exp_t;

    typedef struct {
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [31:0] exp_dig;
    } vec_t;

    exp_t       sbq[$];
    logic [7:0] m_buf [ML];
    int         m_state;   // 0 idle, 1 run, 2 hold
    int         m_cnt;
    int         m_pos;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ML; i++) m_buf[i] = 8'h20;
        m_state = 0;
        m_cnt   = 0;
        m_pos   = 0;
        sbq.delete();
    endtask

    // Behavioural next-cycle model, evaluated with the inputs about to be sampled.
    task automatic model_step();
        exp_t e;
        bit   tick;
        tick = (m_state == 1) && (m_cnt == TD - 1);
        for (int i = 0; i < ND; i++) e.dig[8*(ND-1-i) +: 8] = m_buf[(m_pos + i) % ML];
        e.wrap = tick && !restart && (m_pos == ML - 1);
        if (restart)   m_pos = 0;
        else if (tick) m_pos = (m_pos + 1) % ML;
        if (restart || m_state == 0) m_cnt = 0;
        else if (m_state == 1)       m_cnt = tick ? 0 : m_cnt + 1;
        case (m_state)
            0:       if (enable)  m_state = 1;
            1:       if (!enable) m_state = 2;
            default: if (enable)  m_state = 1;
        endcase
        if (wr_en) m_buf[wr_addr] = wr_data;
        e.pos = 3'(m_pos);
        e.run = (m_state == 1);
        sbq.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        exp_t a;
        model_step();
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        a = {digit_ascii, win_pos, wrap_pulse, running};
        chk("scoreboard", 64'(a), 64'(e));
    endtask

    initial begin
        vec_t vecs[8];
        int   wcnt;
        vecs[0] = '{3'd0, 8'h48, 32'h48202020};
        vecs[1] = '{3'd1, 8'h45, 32'h48452020};
        vecs[2] = '{3'd2, 8'h4C, 32'h48454C20};
        vecs[3] = '{3'd3, 8'h4C, 32'h48454C4C};
        vecs[4] = '{3'd4, 8'h4F, 32'h48454C4C};
        vecs[5] = '{3'd5, 8'h20, 32'h48454C4C};
        vecs[6] = '{3'd6, 8'h31, 32'h48454C4C};
        vecs[7] = '{3'd7, 8'h32, 32'h48454C4C};

        // Asynchronous reset asserted mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_dig", 64'(digit_ascii), 64'h20202020);
        chk("rst_pos", 64'(win_pos), 64'd0);
        chk("rst_run", 64'(running), 64'd0);
        chk("rst_wrap", 64'(wrap_pulse), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Load "HELLO 12" while frozen; each write visible two cycles after it is sampled.
        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; wr_addr = vecs[k].addr; wr_data = vecs[k].data;
            cyc();
            wr_en = 1'b0;
            cyc();
            chk("load_dig", 64'(digit_ascii), 64'(vecs[k].exp_dig));
            chk("load_pos", 64'(win_pos), 64'd0);
        end
        chk("oor_ignored", 64'({dig6, pos6, wrap6, run6}), 64'({32'h48454C4C, 3'd0, 1'b0, 1'b0}));

        // Scroll through a full wrap.
        enable = 1'b1;
        cyc();
        chk("run_entry", 64'(running), 64'd1);
        wcnt = 0;
        for (int k = 1; k <= 36; k++) begin
            cyc();
            wcnt += int'(wrap_pulse);
            if (k == 4)  chk("step1_pos", 64'(win_pos), 64'd1);
            if (k == 5)  chk("step1_dig", 64'(digit_ascii), 64'h454C4C4F);
            if (k == 28) chk("step7_pos", 64'(win_pos), 64'd7);
            if (k == 29) chk("step7_dig", 64'(digit_ascii), 64'h3248454C);
            if (k == 32) chk("wrap_pos", 64'({win_pos, wrap_pulse}), 64'({3'd0, 1'b1}));
            if (k == 33) chk("wrap_dig", 64'(digit_ascii), 64'h48454C4C);
        end
        chk("wrap_count", 64'(wcnt), 64'd1);

        // Freeze with counter at 2, then resume without restarting the count.
        cyc(); cyc();
        enable = 1'b0;
        cyc();
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("hold_pos", 64'(win_pos), 64'd1);
            chk("hold_run", 64'(running), 64'd0);
        end
        enable = 1'b1;
        cyc();
        chk("resume_wait", 64'(win_pos), 64'd1);
        cyc();
        chk("resume_adv", 64'(win_pos), 64'd2);

        // Restart coinciding with the tick that would wrap from 7.
        for (int k = 0; k < 23; k++) cyc();
        chk("pre_restart_pos", 64'(win_pos), 64'd7);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("restart_pos", 64'({win_pos, wrap_pulse}), 64'({3'd0, 1'b0}));
        cyc(); cyc(); cyc();
        chk("restart_wait", 64'({win_pos, wrap_pulse}), 64'({3'd0, 1'b0}));
        cyc();
        chk("restart_adv", 64'(win_pos), 64'd1);

        // Write into a displayed entry while frozen at position 0.
        enable = 1'b0; restart = 1'b1;
        cyc();
        restart = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h31;
        cyc();
        wr_en = 1'b0;
        cyc();
        chk("live_write", 64'(digit_ascii), 64'h48314C4C);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h58;
        cyc();
        wr_en = 1'b0;
        cyc();
        chk("oor_ignored2", 64'(dig6), 64'h48314C4C);

        // Reset in the middle of scrolling clears the buffer too.
        enable = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", 64'({digit_ascii, win_pos, wrap_pulse, running}),
            64'({32'h20202020, 3'd0, 1'b0, 1'b0}));
        enable = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();
        chk("midrst_buf", 64'(digit_ascii), 64'h20202020);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
